// File: rtl/loader_pkg.sv
// Shared types and constants for the program-image loader.
package loader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StHdr,
    StData,
    StWrite,
    StRead,
    StNext,
    StFinish
  } state_e;

  localparam logic [3:0] WSTRB_WRITE = 4'b1111;
  localparam logic [3:0] WSTRB_READ  = 4'b0000;

  function automatic logic [31:0] word_addr(logic [31:0] base, logic [31:0] idx);
    return base + (idx << 2);
  endfunction

endpackage

// File: rtl/word_assembler.sv
// Collects four stream bytes LSB-first into a 32-bit word; full marks the completing byte.
module word_assembler (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        shift,
  input  logic [7:0]  data,
  output logic [31:0] word,
  output logic        full
);

  logic [23:0] sr_q;
  logic [1:0]  cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else if (shift) begin
      sr_q  <= {data, sr_q[23:8]};
      cnt_q <= cnt_q + 2'd1;
    end
  end

  // The word is presented in the same cycle as its last byte so the caller loses no cycle.
  assign word = {data, sr_q};
  assign full = shift && (cnt_q == 2'd3);

endmodule

// File: rtl/mem_loader.sv
// Loads a length-prefixed byte stream into RAM over the PicoRV32 native bus, optionally
// verifies each word, and holds the CPU in reset until a load completes cleanly.
module mem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 1024,
  parameter bit          VERIFY    = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        mem_valid,
  output logic        mem_instr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        mem_sel,
  output logic        cpu_reset_n,
  output logic        busy,
  output logic        done,
  output logic        error
);
  import loader_pkg::*;

  localparam int unsigned IDX_W = $clog2(MAX_WORDS + 1);

  state_e             state_q;
  logic [IDX_W-1:0]   idx_q;
  logic [IDX_W-1:0]   count_q;
  logic [IDX_W-1:0]   idx_nxt;
  logic               xfer;
  logic [31:0]        asm_word;
  logic               asm_full;

  assign xfer      = in_valid && in_ready;
  assign idx_nxt   = idx_q + IDX_W'(1);
  assign mem_instr = 1'b0;

  word_assembler u_word_assembler (
    .clk     (clk),
    .reset_n (reset_n),
    .shift   (xfer),
    .data    (in_data),
    .word    (asm_word),
    .full    (asm_full)
  );

  // Outputs are registered against the state being entered, so they always match state_q.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      count_q     <= '0;
      in_ready    <= 1'b1;
      mem_valid   <= 1'b0;
      mem_addr    <= BASE_ADDR;
      mem_wdata   <= '0;
      mem_wstrb   <= WSTRB_READ;
      mem_sel     <= 1'b0;
      cpu_reset_n <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (xfer) begin
            state_q     <= StHdr;
            busy        <= 1'b1;
            mem_sel     <= 1'b1;
            cpu_reset_n <= 1'b0;
            error       <= 1'b0;
          end
        end
        StHdr: begin
          if (asm_full) begin
            if (asm_word == '0) begin
              state_q     <= StFinish;
              in_ready    <= 1'b0;
              done        <= 1'b1;
              cpu_reset_n <= 1'b1;
              mem_sel     <= 1'b0;
              busy        <= 1'b0;
            end else if (asm_word > 32'(MAX_WORDS)) begin
              // Oversized image: give the port back but keep the CPU in reset.
              state_q <= StIdle;
              error   <= 1'b1;
              mem_sel <= 1'b0;
              busy    <= 1'b0;
            end else begin
              state_q <= StData;
              count_q <= asm_word[IDX_W-1:0];
              idx_q   <= '0;
            end
          end
        end
        StData: begin
          if (asm_full) begin
            state_q   <= StWrite;
            in_ready  <= 1'b0;
            mem_valid <= 1'b1;
            mem_addr  <= word_addr(BASE_ADDR, 32'(idx_q));
            mem_wdata <= asm_word;
            mem_wstrb <= WSTRB_WRITE;
          end
        end
        StWrite: begin
          if (mem_ready) begin
            state_q   <= VERIFY ? StRead : StNext;
            mem_valid <= 1'b0;
            mem_wstrb <= WSTRB_READ;
          end
        end
        StRead: begin
          // First cycle is the mandatory idle gap after the write.
          if (!mem_valid) begin
            mem_valid <= 1'b1;
          end else if (mem_ready) begin
            mem_valid <= 1'b0;
            state_q   <= StNext;
            if (mem_rdata != mem_wdata) error <= 1'b1;
          end
        end
        StNext: begin
          idx_q <= idx_nxt;
          if (idx_nxt == count_q) begin
            state_q     <= StFinish;
            done        <= !error;
            cpu_reset_n <= !error;
            mem_sel     <= 1'b0;
            busy        <= 1'b0;
          end else begin
            state_q  <= StData;
            in_ready <= 1'b1;
          end
        end
        StFinish: begin
          state_q  <= StIdle;
          in_ready <= 1'b1;
        end
        default: begin
          state_q  <= StIdle;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
